layer_out_serializer: RTL and testbench

//  Sits between the neuron array of one fully connected layer and the neurons of the next layer.

---
 rtl/layer_out_serializer.sv | 133 +++++++++++++
 tb/tb_layer_out_serializer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/layer_out_serializer.sv
// layer_out_serializer
// Captures one layer's parallel activations when every neuron strobes valid
// and streams them one word per cycle to the next layer. Back-to-back frames
// stream without a gap. Sticky flags record dropped and partially strobed frames.
module layer_out_serializer #(
    parameter int NUM_NEURONS = 30,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] neuron_out,
    input  logic [NUM_NEURONS-1:0]            neuron_valid,
    input  logic                              err_clr,
    output logic [DATA_WIDTH-1:0]             out_data,
    output logic                              out_valid,
    output logic                              layer_done,
    output logic                              busy,
    output logic                              err_overrun,
    output logic                              err_partial
);

    localparam int CNT_W = $clog2(NUM_NEURONS);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t                  state, state_next;
    logic [CNT_W-1:0]        cnt, cnt_next;
    logic [DATA_WIDTH-1:0]   capture [NUM_NEURONS];

    logic                    accept;
    logic                    partial;
    logic                    last_word;
    logic                    load;
    logic                    overrun;
    logic [DATA_WIDTH-1:0]   out_data_next;
    logic                    out_valid_next;
    logic                    layer_done_next;
    logic                    busy_next;

    // A frame is only taken when the whole layer fires together.
    assign accept    = &neuron_valid;
    assign partial   = (|neuron_valid) & ~accept;
    assign last_word = (cnt == CNT_W'(NUM_NEURONS - 1));

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state and next-output decode; cnt indexes the word being presented.
    always_comb begin
        // NOTE: defaults first, so every path assigns every signal and no latch is inferred.
        state_next      = state;
        cnt_next        = cnt;
        out_data_next   = out_data;
        out_valid_next  = 1'b0;
        busy_next       = 1'b0;
        layer_done_next = 1'b0;
        load            = 1'b0;
        overrun         = 1'b0;

        case (state)
            IDLE: begin
                if (accept) begin
                    load           = 1'b1;
                    cnt_next       = '0;
                    state_next     = SHIFT;
                    out_data_next  = neuron_out[DATA_WIDTH-1:0];
                    out_valid_next = 1'b1;
                    busy_next      = 1'b1;
                end
            end
            SHIFT: begin
                if (!last_word) begin
                    cnt_next       = cnt + 1'b1;
                    out_data_next  = capture[cnt_next];
                    out_valid_next = 1'b1;
                    busy_next      = 1'b1;
                    overrun        = accept;
                end else begin
                    layer_done_next = 1'b1;
                    if (accept) begin
                        load           = 1'b1;
                        cnt_next       = '0;
                        out_data_next  = neuron_out[DATA_WIDTH-1:0];
                        out_valid_next = 1'b1;
                        busy_next      = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs, word index and sticky error flags (a new error beats err_clr).
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= '0;
            out_data    <= '0;
            out_valid   <= 1'b0;
            busy        <= 1'b0;
            layer_done  <= 1'b0;
            err_overrun <= 1'b0;
            err_partial <= 1'b0;
        end else begin
            cnt         <= cnt_next;
            out_data    <= out_data_next;
            out_valid   <= out_valid_next;
            busy        <= busy_next;
            layer_done  <= layer_done_next;
            err_overrun <= overrun ? 1'b1 : (err_clr ? 1'b0 : err_overrun);
            err_partial <= partial ? 1'b1 : (err_clr ? 1'b0 : err_partial);
        end
    end

    // Capture register: written only on a successful accept.
    always_ff @(posedge clk) begin
        // NOTE: this small register array is cleared on reset; large RAMs normally are not.
        if (rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) capture[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < NUM_NEURONS; i++) capture[i] <= neuron_out[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

endmodule

// File: tb/tb_layer_out_serializer.sv
// Testbench for layer_out_serializer (NUM_NEURONS=4, DATA_WIDTH=16).
// A queue-based model predicts every output each cycle; a vector table and
// hand-written sequences pin the documented corner cases to constants.
module tb_layer_out_serializer;

    localparam int N  = 4;
    localparam int DW = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*DW-1:0] neuron_out;
    logic [N-1:0]    neuron_valid;
    logic            err_clr;
    logic [DW-1:0]   out_data;
    logic            out_valid;
    logic            layer_done;
    logic            busy;
    logic            err_overrun;
    logic            err_partial;

    int n_checks = 0;
    int n_fail   = 0;

    layer_out_serializer #(.NUM_NEURONS(N), .DATA_WIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .neuron_out   (neuron_out),
        .neuron_valid (neuron_valid),
        .err_clr      (err_clr),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .layer_done   (layer_done),
        .busy         (busy),
        .err_overrun  (err_overrun),
        .err_partial  (err_partial)
    );

    always #5 clk = ~clk;

    // Reference model: the words still to be shown, front = word on out_data now.
    logic [DW-1:0] m_q[$];
    logic [DW-1:0] m_data;
    logic          m_ld;
    logic          m_ovr;
    logic          m_par;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic c, input logic [N-1:0] v, input logic [N*DW-1:0] d);
        bit shown, last, acc, part, ovr_evt;
        if (r) begin
            m_q.delete();
            m_data = '0;
            m_ld   = 1'b0;
            m_ovr  = 1'b0;
            m_par  = 1'b0;
            return;
        end
        shown   = (m_q.size() > 0);
        last    = (m_q.size() == 1);
        acc     = (v == {N{1'b1}});
        part    = (v != '0) && !acc;
        ovr_evt = 1'b0;
        if (shown) void'(m_q.pop_front());
        if (acc) begin
            if (!shown || last) begin
                for (int i = 0; i < N; i++) m_q.push_back(d[i*DW +: DW]);
            end else begin
                ovr_evt = 1'b1;
            end
        end
        m_ld  = last;
        m_ovr = ovr_evt ? 1'b1 : (c ? 1'b0 : m_ovr);
        m_par = part    ? 1'b1 : (c ? 1'b0 : m_par);
        if (m_q.size() > 0) m_data = m_q[0];
    endtask

    // Apply one cycle of inputs, advance the model, compare all outputs after the edge.
    task automatic step(input logic r, input logic c, input logic [N-1:0] v, input logic [N*DW-1:0] d);
        rst          = r;
        err_clr      = c;
        neuron_valid = v;
        neuron_out   = d;
        @(posedge clk);
        #1;
        model_step(r, c, v, d);
        check("m_out_valid",   64'(out_valid),   64'(m_q.size() > 0));
        check("m_busy",        64'(busy),        64'(m_q.size() > 0));
        check("m_out_data",    64'(out_data),    64'(m_data));
        check("m_layer_done",  64'(layer_done),  64'(m_ld));
        check("m_err_overrun", 64'(err_overrun), 64'(m_ovr));
        check("m_err_partial", 64'(err_partial), 64'(m_par));
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 1'b0, '0, 64'h0);
    endtask

    typedef struct {
        logic [N-1:0]    valid;
        logic [N*DW-1:0] data;
        logic            exp_valid;
        logic [DW-1:0]   exp_data;
        logic            exp_ld;
    } vec_t;

    function automatic vec_t mk(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                                input logic ev, input logic [DW-1:0] ed, input logic el);
        vec_t t;
        t.valid = v; t.data = d; t.exp_valid = ev; t.exp_data = ed; t.exp_ld = el;
        return t;
    endfunction

    localparam logic [N*DW-1:0] F1 = 64'h0004_0003_0002_0001;
    localparam logic [N*DW-1:0] F2 = 64'h000D_000C_000B_000A;
    localparam logic [N*DW-1:0] F3 = 64'h0000_7FFF_FFFF_8000;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[$];
        logic [N-1:0] v;
        int r;

        // Reset state.
        step(1'b1, 1'b0, '0, 64'h0);
        step(1'b1, 1'b0, '0, 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_busy",      64'(busy),      64'd0);
        check("rst_flags",     64'({layer_done, err_overrun, err_partial}), 64'd0);
        idle(2);

        // Single frame, back-to-back frame, then negative data bit-exact.
        vecs.push_back(mk(4'hF, F1,                    1'b1, 16'h0001, 1'b0));
        vecs.push_back(mk(4'h0, 64'hDEAD_BEEF_1234_5678, 1'b1, 16'h0002, 1'b0));
        vecs.push_back(mk(4'h0, 64'h0,                 1'b1, 16'h0003, 1'b0));
        vecs.push_back(mk(4'h0, 64'h0,                 1'b1, 16'h0004, 1'b0));
        vecs.push_back(mk(4'hF, F2,                    1'b1, 16'h000A, 1'b1));
        vecs.push_back(mk(4'h0, 64'h0,                 1'b1, 16'h000B, 1'b0));
        vecs.push_back(mk(4'h0, 64'h0,                 1'b1, 16'h000C, 1'b0));
        vecs.push_back(mk(4'h0, 64'h0,                 1'b1, 16'h000D, 1'b0));
        vecs.push_back(mk(4'h0, 64'h0,                 1'b0, 16'h000D, 1'b1));
        vecs.push_back(mk(4'h0, 64'h0,                 1'b0, 16'h000D, 1'b0));
        vecs.push_back(mk(4'hF, F3,                    1'b1, 16'h8000, 1'b0));
        vecs.push_back(mk(4'h0, 64'h0,                 1'b1, 16'hFFFF, 1'b0));
        vecs.push_back(mk(4'h0, 64'h0,                 1'b1, 16'h7FFF, 1'b0));
        vecs.push_back(mk(4'h0, 64'h0,                 1'b1, 16'h0000, 1'b0));
        vecs.push_back(mk(4'h0, 64'h0,                 1'b0, 16'h0000, 1'b1));
        foreach (vecs[i]) begin
            step(1'b0, 1'b0, vecs[i].valid, vecs[i].data);
            check($sformatf("vec%0d_out_valid", i),  64'(out_valid),  64'(vecs[i].exp_valid));
            check($sformatf("vec%0d_busy", i),       64'(busy),       64'(vecs[i].exp_valid));
            check($sformatf("vec%0d_out_data", i),   64'(out_data),   64'(vecs[i].exp_data));
            check($sformatf("vec%0d_layer_done", i), 64'(layer_done), 64'(vecs[i].exp_ld));
        end
        idle(2);

        // Overrun: second full strobe two cycles into a frame is dropped.
        step(1'b0, 1'b0, 4'hF, F1);                 // T   -> word1 at T+1
        step(1'b0, 1'b0, 4'h0, 64'h0);              // T+1 -> word2 at T+2
        step(1'b0, 1'b0, 4'hF, F2);                 // T+2 -> word3 at T+3
        check("ovr_flag",  64'(err_overrun), 64'd1);
        check("ovr_word3", 64'(out_data),    64'h0003);
        step(1'b0, 1'b0, 4'h0, 64'h0);
        check("ovr_word4", 64'(out_data),    64'h0004);
        step(1'b0, 1'b0, 4'h0, 64'h0);
        check("ovr_done",  64'({out_valid, layer_done}), 64'b01);
        idle(5);                                    // cycles T+5..T+9
        check("ovr_sticky", 64'(err_overrun), 64'd1);
        step(1'b0, 1'b1, 4'h0, 64'h0);              // err_clr at T+10
        check("ovr_cleared", 64'(err_overrun), 64'd0);

        // Partial strobe: no stream, sticky partial flag; error beats a same-cycle clear.
        step(1'b0, 1'b0, 4'b0101, F1);
        check("par_flag",  64'(err_partial), 64'd1);
        check("par_idle",  64'({out_valid, busy}), 64'd0);
        step(1'b0, 1'b1, 4'b0010, F1);
        check("par_wins_clr", 64'(err_partial), 64'd1);
        step(1'b0, 1'b1, 4'h0, 64'h0);
        check("par_cleared", 64'(err_partial), 64'd0);

        // Reset mid-frame, then a fresh frame from word0.
        step(1'b0, 1'b0, 4'hF, F2);
        step(1'b0, 1'b0, 4'h0, 64'h0);
        step(1'b1, 1'b0, 4'h0, 64'h0);              // rst at T+2
        check("rstmid_idle", 64'({out_valid, busy}), 64'd0);
        idle(5);
        step(1'b0, 1'b0, 4'hF, F1);
        check("rstmid_word0", 64'(out_data), 64'h0001);
        step(1'b0, 1'b0, 4'h0, 64'h0);
        check("rstmid_word1", 64'(out_data), 64'h0002);
        idle(4);

        // Randomized traffic against the model.
        for (int c = 0; c < 600; c++) begin
            r = $urandom_range(0, 9);
            if (r <= 5)      v = '0;
            else if (r <= 8) v = '1;
            else             v = 4'($urandom_range(1, 14));
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0), v,
                 {$urandom(), $urandom()});
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
